// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU sequencer.
// Holds the opcode map, the ALU select codes, the FSM state encoding,
// the decoded-instruction payload and the NEEDS_IMM helper.
package cpu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned SEL_W  = 4;

    // Opcodes, taken from instruction byte [7:4]
    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
    localparam logic [OP_W-1:0] OP_MUL  = 4'h3;
    localparam logic [OP_W-1:0] OP_AND  = 4'h4;
    localparam logic [OP_W-1:0] OP_OR   = 4'h5;
    localparam logic [OP_W-1:0] OP_NOT  = 4'h6;
    localparam logic [OP_W-1:0] OP_JMP  = 4'h7;
    localparam logic [OP_W-1:0] OP_HALT = 4'h8;

    // ALU select codes
    localparam logic [SEL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [SEL_W-1:0] ALU_MUL  = 4'b0001;
    localparam logic [SEL_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [SEL_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [SEL_W-1:0] ALU_NOT  = 4'b0100;
    localparam logic [SEL_W-1:0] ALU_PASS = 4'b0111;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_OP  = 3'd1,
        ST_FETCH_IMM = 3'd2,
        ST_EXEC      = 3'd3,
        ST_HALT      = 3'd4,
        ST_ERROR     = 3'd5
    } state_t;

    typedef struct packed {
        logic             needs_imm;
        logic             writes_acc;
        logic [SEL_W-1:0] alu_sel;
        logic             in1_is_imm;
        logic             is_jmp;
        logic             is_halt;
        logic             illegal;
    } dec_t;

    // Opcodes followed by an 8-bit immediate byte
    function automatic logic needs_imm(input logic [OP_W-1:0] op);
        logic r;
        case (op)
            OP_LDI, OP_ADD, OP_MUL, OP_AND, OP_OR, OP_JMP: r = 1'b1;
            default:                                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_decoder.sv
// Combinational opcode decoder.
// Ports:
//   opcode  in   4-bit instruction opcode
//   dec     out  decoded control payload (needs_imm, writes_acc, alu_sel,
//                in1_is_imm, is_jmp, is_halt, illegal)
module cpu_decoder
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output dec_t            dec
);

    // Opcode to control-field mapping; unlisted opcodes are illegal
    always_comb begin
        dec           = '0;
        dec.needs_imm = needs_imm(opcode);
        case (opcode)
            OP_NOP: begin
            end
            OP_LDI: begin
                dec.writes_acc = 1'b1;
                dec.alu_sel    = ALU_PASS;
                dec.in1_is_imm = 1'b1;
            end
            OP_ADD: begin
                dec.writes_acc = 1'b1;
                dec.alu_sel    = ALU_ADD;
            end
            OP_MUL: begin
                dec.writes_acc = 1'b1;
                dec.alu_sel    = ALU_MUL;
            end
            OP_AND: begin
                dec.writes_acc = 1'b1;
                dec.alu_sel    = ALU_AND;
            end
            OP_OR: begin
                dec.writes_acc = 1'b1;
                dec.alu_sel    = ALU_OR;
            end
            OP_NOT: begin
                dec.writes_acc = 1'b1;
                dec.alu_sel    = ALU_NOT;
            end
            OP_JMP:  dec.is_jmp  = 1'b1;
            OP_HALT: dec.is_halt = 1'b1;
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for an 8-bit accumulator CPU. Fetches
// 1- or 2-byte instructions, drives the ALU and strobes the result back
// into the accumulator.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   start                    begin execution at RESET_PC (IDLE/HALT/ERROR only)
//   imem_req/imem_addr       fetch request and address (held until imem_valid)
//   imem_data/imem_valid     fetched byte and completion
//   acc_rd                   current accumulator value
//   alu_sel/alu_in1/alu_in2  ALU control and operands (EXEC only)
//   alu_result               combinational ALU output
//   acc_wr_en/acc_wr_data    one-cycle accumulator write
//   pc                       program counter
//   busy/halted/err          status
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_data,
    input  logic              imem_valid,
    input  logic [7:0]        acc_rd,
    output logic [3:0]        alu_sel,
    output logic [7:0]        alu_in1,
    output logic [7:0]        alu_in2,
    input  logic [7:0]        alu_result,
    output logic              acc_wr_en,
    output logic [7:0]        acc_wr_data,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [OP_W-1:0]     dec_op;
    dec_t                dec;
    logic                unused_ir_low;

    // Only the opcode nibble of the instruction register is meaningful
    assign unused_ir_low = ^ir_q[3:0];

    // Decode the byte arriving from memory during FETCH_OP, else the latched opcode
    assign dec_op = (state_q == ST_FETCH_OP) ? imem_data[7:4] : ir_q[7:4];

    cpu_decoder u_decoder (
        .opcode (dec_op),
        .dec    (dec)
    );

    assign pc = pc_q;

    // State and architectural registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= ADDR_W'(RESET_PC);
            ir_q    <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
        end
    end

    // Next-state, register updates and datapath control
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        imm_d       = imm_q;
        imem_req    = 1'b0;
        imem_addr   = '0;
        alu_sel     = ALU_ADD;
        alu_in1     = '0;
        alu_in2     = '0;
        acc_wr_en   = 1'b0;
        acc_wr_data = '0;
        busy        = 1'b0;
        halted      = 1'b0;
        err         = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT, ST_ERROR: begin
                halted = (state_q == ST_HALT);
                err    = (state_q == ST_ERROR);
                if (start) begin
                    pc_d    = ADDR_W'(RESET_PC);
                    state_d = ST_FETCH_OP;
                end
            end

            ST_FETCH_OP: begin
                busy      = 1'b1;
                imem_req  = 1'b1;
                imem_addr = pc_q;
                if (imem_valid) begin
                    ir_d = imem_data;
                    pc_d = pc_q + ADDR_W'(1);
                    if (dec.illegal) begin
                        state_d = ST_ERROR;
                    end else if (dec.is_halt) begin
                        state_d = ST_HALT;
                    end else if (dec.needs_imm) begin
                        state_d = ST_FETCH_IMM;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end

            ST_FETCH_IMM: begin
                busy      = 1'b1;
                imem_req  = 1'b1;
                imem_addr = pc_q;
                if (imem_valid) begin
                    imm_d   = imem_data;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                busy = 1'b1;
                if (dec.writes_acc) begin
                    alu_sel     = dec.alu_sel;
                    alu_in1     = dec.in1_is_imm ? imm_q : acc_rd;
                    // Second operand only exists for the acc-op-imm forms
                    alu_in2     = (dec.needs_imm && !dec.in1_is_imm) ? imm_q : '0;
                    acc_wr_en   = 1'b1;
                    acc_wr_data = alu_result;
                end
                if (dec.is_jmp) begin
                    pc_d = ADDR_W'(imm_q);
                end
                state_d = ST_FETCH_OP;
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: memory with programmable wait states,
// reference ALU and accumulator, and a queue of expected accumulator writes.
module tb_cpu_sequencer;

    localparam int unsigned AW = 4;

    typedef struct {
        logic [7:0] data;
        logic [3:0] sel;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [7:0]    imem_data;
    logic          imem_valid;
    logic [7:0]    acc_rd;
    logic [3:0]    alu_sel;
    logic [7:0]    alu_in1;
    logic [7:0]    alu_in2;
    logic [7:0]    alu_result;
    logic          acc_wr_en;
    logic [7:0]    acc_wr_data;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;
    logic          err;

    logic [7:0]    mem [16];
    logic [7:0]    acc = 8'h00;
    int            wait_cycles = 0;
    int            wcnt = 0;
    logic          spurious = 1'b0;

    int            n_vec = 0;
    int            n_bad = 0;
    exp_t          sb[$];
    logic [AW-1:0] fetch_log[$];
    logic          stab_pending = 1'b0;
    logic [AW-1:0] stab_addr = '0;

    cpu_sequencer #(.ADDR_W(AW), .RESET_PC(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .imem_valid  (imem_valid),
        .acc_rd      (acc_rd),
        .alu_sel     (alu_sel),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_result  (alu_result),
        .acc_wr_en   (acc_wr_en),
        .acc_wr_data (acc_wr_data),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Instruction memory with wait_cycles wait states per fetch
    assign imem_data  = mem[imem_addr];
    assign imem_valid = (imem_req && (wcnt >= wait_cycles)) || spurious;
    always @(posedge clk) begin
        if (!imem_req || imem_valid) wcnt <= 0;
        else                         wcnt <= wcnt + 1;
    end

    // Reference ALU and accumulator
    always_comb begin
        case (alu_sel)
            4'b0000: alu_result = 8'(alu_in1 + alu_in2);
            4'b0001: alu_result = 8'(alu_in1 * alu_in2);
            4'b0010: alu_result = alu_in1 & alu_in2;
            4'b0011: alu_result = alu_in1 | alu_in2;
            4'b0100: alu_result = ~alu_in1;
            4'b0111: alu_result = alu_in1;
            default: alu_result = 8'h00;
        endcase
    end
    assign acc_rd = acc;
    always @(posedge clk) if (acc_wr_en) acc <= acc_wr_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write scoreboard, fetch stability and fetch address log
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && acc_wr_en) begin
            chk("wr_in_busy", 32'(busy), 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(acc_wr_en), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wr_data", 32'(acc_wr_data), 32'(e.data));
                chk("wr_sel", 32'(alu_sel), 32'(e.sel));
            end
        end
        if (rst_n && stab_pending) begin
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_stable", 32'(imem_addr), 32'(stab_addr));
        end
        stab_pending = rst_n && imem_req && !imem_valid;
        stab_addr    = imem_addr;
        if (rst_n && imem_req && imem_valid) fetch_log.push_back(imem_addr);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    endtask

    task automatic push(input logic [7:0] d, input logic [3:0] s);
        exp_t e;
        e.data = d;
        e.sel  = s;
        sb.push_back(e);
    endtask

    task automatic wait_stop(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted || err) break;
        end
        if (i == budget) chk("stop_timeout", 32'(halted | err), 32'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req"},    32'(imem_req),    32'd0);
        chk({tag, "_addr"},   32'(imem_addr),   32'd0);
        chk({tag, "_wr_en"},  32'(acc_wr_en),   32'd0);
        chk({tag, "_sel"},    32'(alu_sel),     32'd0);
        chk({tag, "_in1"},    32'(alu_in1),     32'd0);
        chk({tag, "_wrdata"}, 32'(acc_wr_data), 32'd0);
        chk({tag, "_busy"},   32'(busy),        32'd0);
        chk({tag, "_halted"}, 32'(halted),      32'd0);
        chk({tag, "_err"},    32'(err),         32'd0);
        chk({tag, "_pc"},     32'(pc),          32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        clear_mem();

        // Reset state
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2);
        chk("idle_no_start_busy", 32'(busy), 32'd0);

        // T1: LDI 05; ADD 03; HALT
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h05; mem[2] = 8'h20; mem[3] = 8'h03; mem[4] = 8'h80;
        push(8'h05, 4'b0111);
        push(8'h08, 4'b0000);
        pulse_start();
        wait_stop(100);
        chk("t1_halted", 32'(halted), 32'd1);
        chk("t1_pc", 32'(pc), 32'd5);
        chk("t1_acc", 32'(acc), 32'h08);
        chk("t1_sb", 32'(sb.size()), 32'd0);

        // T2: LDI 10; MUL 20; LDI 0F; NOT
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h10; mem[2] = 8'h30; mem[3] = 8'h20;
        mem[4] = 8'h10; mem[5] = 8'h0F; mem[6] = 8'h60; mem[7] = 8'h80;
        push(8'h10, 4'b0111);
        push(8'h00, 4'b0001);
        push(8'h0F, 4'b0111);
        push(8'hF0, 4'b0100);
        pulse_start();
        wait_stop(100);
        chk("t2_halted", 32'(halted), 32'd1);
        chk("t2_pc", 32'(pc), 32'd8);
        chk("t2_sb", 32'(sb.size()), 32'd0);

        // T3: LDI 06; AND 05; OR 09, with a start pulse while busy
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h06; mem[2] = 8'h40; mem[3] = 8'h05;
        mem[4] = 8'h50; mem[5] = 8'h09; mem[6] = 8'h80;
        push(8'h06, 4'b0111);
        push(8'h04, 4'b0010);
        push(8'h0D, 4'b0011);
        pulse_start();
        tick(2);
        chk("t3_busy_before_start", 32'(busy), 32'd1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_stop(100);
        chk("t3_halted", 32'(halted), 32'd1);
        chk("t3_pc", 32'(pc), 32'd7);
        chk("t3_sb", 32'(sb.size()), 32'd0);

        // imem_valid without a request is ignored while halted
        spurious = 1'b1;
        tick(3);
        spurious = 1'b0;
        chk("spurious_busy", 32'(busy), 32'd0);
        chk("spurious_halted", 32'(halted), 32'd1);
        chk("spurious_pc", 32'(pc), 32'd7);

        // T4: three wait states per fetch; LDI AA takes 9 cycles
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'hAA; mem[2] = 8'h80;
        wait_cycles = 3;
        push(8'hAA, 4'b0111);
        pulse_start();
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy) n++;
            if (acc_wr_en) break;
        end
        chk("t4_cycles", 32'(n), 32'd9);
        wait_stop(100);
        chk("t4_pc", 32'(pc), 32'd3);
        chk("t4_sb", 32'(sb.size()), 32'd0);
        wait_cycles = 0;

        // T5: JMP 0E, NOPs at E and F, PC wraps to 0 where HALT is patched in
        clear_mem();
        mem[0] = 8'h70; mem[1] = 8'h0E; mem[14] = 8'h00; mem[15] = 8'h00;
        fetch_log.delete();
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pc == 4'hE) break;
        end
        chk("t5_jmp_target", 32'(pc), 32'hE);
        mem[0] = 8'h80;
        wait_stop(100);
        chk("t5_halted", 32'(halted), 32'd1);
        chk("t5_pc", 32'(pc), 32'd1);
        chk("t5_nfetch", 32'(fetch_log.size()), 32'd5);
        if (fetch_log.size() == 5) begin
            chk("t5_f0", 32'(fetch_log[0]), 32'h0);
            chk("t5_f1", 32'(fetch_log[1]), 32'h1);
            chk("t5_f2", 32'(fetch_log[2]), 32'hE);
            chk("t5_f3", 32'(fetch_log[3]), 32'hF);
            chk("t5_f4", 32'(fetch_log[4]), 32'h0);
        end

        // Illegal opcode goes to ERROR without writing
        mem[0] = 8'hF0;
        pulse_start();
        wait_stop(50);
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_err_halted", 32'(halted), 32'd0);
        chk("t5_err_pc", 32'(pc), 32'd1);

        // Restart from ERROR
        mem[0] = 8'h10; mem[1] = 8'h33; mem[2] = 8'h80;
        push(8'h33, 4'b0111);
        pulse_start();
        wait_stop(50);
        chk("t5_restart_halted", 32'(halted), 32'd1);
        chk("t5_restart_err", 32'(err), 32'd0);
        chk("t5_restart_pc", 32'(pc), 32'd3);
        chk("t5_sb", 32'(sb.size()), 32'd0);

        // T6a: reset asserted during FETCH_IMM
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h55; mem[2] = 8'h80;
        wait_cycles = 2;
        pulse_start();
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 4'd1) begin
                n = 1;
                break;
            end
        end
        chk("t6_reached_imm", 32'(n), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("t6a");
        tick(2);
        rst_n = 1'b1;
        tick(4);
        chk("t6a_idle_busy", 32'(busy), 32'd0);
        chk("t6a_idle_req", 32'(imem_req), 32'd0);
        chk("t6a_acc_kept", 32'(acc), 32'h33);

        // T6b: reset asserted during EXEC of LDI 55
        wait_cycles = 0;
        pulse_start();
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (acc_wr_en) begin
                n = 1;
                break;
            end
        end
        chk("t6_reached_exec", 32'(n), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("t6b");
        tick(2);
        chk("t6b_acc_kept", 32'(acc), 32'h33);
        rst_n = 1'b1;
        tick(4);
        chk("t6b_idle_busy", 32'(busy), 32'd0);
        chk("t6b_idle_req", 32'(imem_req), 32'd0);
        chk("final_sb", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
